// File: rtl/decoder_4to16_pkg.sv
// Shared constants and the reference one-hot decode function for decoder_4to16.
package decoder_4to16_pkg;

  // Default select width; the output width is always 2**SEL_W.
  localparam int SEL_W_DEFAULT = 4;
  localparam int OUT_W_DEFAULT = 2 ** SEL_W_DEFAULT;

  // One-hot decode at the default width: bit 'sel' set when enabled, else zero.
  function automatic logic [OUT_W_DEFAULT-1:0] onehot_decode(
    input logic [SEL_W_DEFAULT-1:0] sel,
    input logic                     enable
  );
    logic [OUT_W_DEFAULT-1:0] d;
    d = '0;
    if (enable) begin
      d[sel] = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Parameterised combinational binary-to-one-hot decode with active-high enable.
module decoder_core #(
  parameter int SEL_W = 4,
  parameter int OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             enable,
  output logic [OUT_W-1:0] d
);

  // One comparator per output bit; an unknown sel propagates X while enabled.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
      assign d[gi] = enable && (sel == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/decoder_4to16.sv
// Binary-to-one-hot decoder: zero-latency decode D plus a registered copy
// (D_q) with the captured enable (valid_q) and select (sel_q).
module decoder_4to16
  import decoder_4to16_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  enable,
  output logic [2**SEL_W-1:0]   D,
  output logic [2**SEL_W-1:0]   D_q,
  output logic                  valid_q,
  output logic [SEL_W-1:0]      sel_q
);

  localparam int OUT_W = 2 ** SEL_W;

  logic [OUT_W-1:0] d_d;

  decoder_core #(
    .SEL_W (SEL_W),
    .OUT_W (OUT_W)
  ) u_core (
    .sel    (sel),
    .enable (enable),
    .d      (d_d)
  );

  // The combinational decode is independent of clock and reset.
  assign D = d_d;

  // Output register stage; clears asynchronously, captures sel even when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D_q     <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      D_q     <= d_d;
      valid_q <= enable;
      sel_q   <= sel;
    end
  end

endmodule

// File: tb/tb_decoder_4to16.sv
// Self-checking bench for decoder_4to16: vector table, hand sequences for
// reset corner cases, and a randomised run, with a scoreboard queue for the
// registered outputs.
module tb_decoder_4to16;
  import decoder_4to16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic        enable = 1'b0;
  logic [15:0] D;
  logic [15:0] D_q;
  logic        valid_q;
  logic [3:0]  sel_q;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        v;
    logic [3:0]  s;
  } reg_exp_t;

  typedef struct {
    logic [3:0]  sel;
    logic        en;
    logic [15:0] exp_d;
  } vec_t;

  reg_exp_t sb_q[$];
  vec_t     vecs[21];

  decoder_4to16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .enable  (enable),
    .D       (D),
    .D_q     (D_q),
    .valid_q (valid_q),
    .sel_q   (sel_q)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one transaction at the falling edge, check D, then check the registered copy.
  task automatic step(input logic [3:0] s, input logic e, input logic [15:0] exp_d, input string tag);
    reg_exp_t x;
    sel    = s;
    enable = e;
    #1;
    check({tag, " D"}, 32'(D), 32'(exp_d));
    sb_q.push_back('{d: exp_d, v: e, s: s});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      check({tag, " D_q"}, 32'(D_q), 32'(x.d));
      check({tag, " valid_q"}, 32'(valid_q), 32'(x.v));
      check({tag, " sel_q"}, 32'(sel_q), 32'(x.s));
    end
    $display("%s sel=%0d en=%0b D=%h D_q=%h valid_q=%0b sel_q=%0d", tag, s, e, D, D_q, valid_q, sel_q);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  rs;
    logic        re;
    logic [15:0] rexp;

    // Sweep with enable high: D = 1 << sel.
    for (int i = 0; i < 16; i++) begin
      vecs[i].sel   = 4'(i);
      vecs[i].en    = 1'b1;
      vecs[i].exp_d = 16'h0001 << i;
    end
    vecs[16] = '{sel: 4'd5,  en: 1'b0, exp_d: 16'h0000};
    vecs[17] = '{sel: 4'd3,  en: 1'b0, exp_d: 16'h0000};
    vecs[18] = '{sel: 4'd12, en: 1'b1, exp_d: 16'h1000};
    vecs[19] = '{sel: 4'd15, en: 1'b1, exp_d: 16'h8000};
    vecs[20] = '{sel: 4'd0,  en: 1'b1, exp_d: 16'h0001};

    // Reset state, before any clock edge.
    #3;
    check("reset D", 32'(D), 32'h0);
    check("reset D_q", 32'(D_q), 32'h0);
    check("reset valid_q", 32'(valid_q), 32'h0);
    check("reset sel_q", 32'(sel_q), 32'h0);

    // D is live during reset; registers hold zero across an edge.
    sel = 4'd7;
    enable = 1'b1;
    #1;
    check("in-reset D", 32'(D), 32'h0080);
    @(posedge clk);
    #1;
    check("in-reset D_q", 32'(D_q), 32'h0);
    check("in-reset valid_q", 32'(valid_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].sel, vecs[i].en, vecs[i].exp_d, $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-sweep with enable=1, sel=9.
    step(4'd9, 1'b1, 16'h0200, "pre-rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async-rst D_q", 32'(D_q), 32'h0);
    check("async-rst valid_q", 32'(valid_q), 32'h0);
    check("async-rst sel_q", 32'(sel_q), 32'h0);
    check("async-rst D", 32'(D), 32'h0200);
    $display("async-rst D=%h D_q=%h valid_q=%0b sel_q=%0d", D, D_q, valid_q, sel_q);
    @(posedge clk);
    #1;
    check("held-rst D_q", 32'(D_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'd10, 1'b1, 16'h0400, "post-rst");

    // Simultaneous change of sel and enable.
    step(4'd3, 1'b0, 16'h0000, "pair-a");
    step(4'd12, 1'b1, 16'h1000, "pair-b");

    // Randomised run.
    for (int i = 0; i < 1000; i++) begin
      rs = 4'($urandom_range(0, 15));
      re = 1'($urandom_range(0, 1));
      rexp = onehot_decode(rs, re);
      sel = rs;
      enable = re;
      #1;
      check("rand popcount", 32'($countones(D) <= 1), 32'd1);
      @(negedge clk);
      step(rs, re, rexp, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
